// File: rtl/asi_pkg.sv
// asi_pkg: owner encoding and priority constants shared by the ASI
// user-side arbiter and its neighbours.
package asi_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'b00,
    ARB_RD   = 2'b01,
    ARB_WR   = 2'b10
  } ARB_ST;

  localparam int SLV_ARB_RD = 1;
  localparam int SLV_ARB_WR = 0;

endpackage

// File: rtl/asi_arb.sv
// asi_arb: burst-atomic arbiter between the ASI read and write engines
// for the single user-side memory port, with a streak limiter.
module asi_arb
  import asi_pkg::*;
#(
  parameter int SLV_ARB  = 0,
  parameter int ARB_MAXB = 4
) (
  input  logic       usr_clk,
  input  logic       usr_reset,
  input  logic       m_arff_rvalid,
  input  logic       m_rbusy,
  input  logic       m_awff_rvalid,
  input  logic       m_wbusy,
  output logic       rgranted,
  output logic       wgranted,
  output logic [1:0] arb_owner,
  output logic       arb_err
);

  localparam int ARB_CW =
    (ARB_MAXB > 0) ? $clog2(ARB_MAXB + 1) : 1;

  ARB_ST             state;
  logic [ARB_CW-1:0] streak;
  logic              rd_own;
  logic              wr_own;
  logic              hold;
  logic              lim;
  logic              start;
  logic              same;
  logic              bad;

  assign rd_own = (state == ARB_RD);
  assign wr_own = (state == ARB_WR);
  assign hold   = (rd_own && m_rbusy) || (wr_own && m_wbusy);
  assign lim    = (ARB_MAXB != 0) &&
                  (streak >= ARB_CW'(ARB_MAXB));

  always_comb begin
    rgranted = 1'b0;
    wgranted = 1'b0;
    if (!usr_reset) begin
      if (hold) begin
        rgranted = rd_own;
        wgranted = wr_own;
      end else if (m_arff_rvalid && m_awff_rvalid) begin
        // preferred side yields only when it has hit its streak limit
        if (SLV_ARB == SLV_ARB_RD) begin
          rgranted = !(rd_own && lim);
          wgranted = !rgranted;
        end else begin
          wgranted = !(wr_own && lim);
          rgranted = !wgranted;
        end
      end else begin
        rgranted = m_arff_rvalid;
        wgranted = m_awff_rvalid;
      end
    end
  end

  assign start = !usr_reset && !hold && (rgranted || wgranted);
  assign same  = rgranted ? rd_own : wr_own;
  assign bad   = (m_rbusy && !rd_own) ||
                 (m_wbusy && !wr_own) ||
                 (m_rbusy && m_wbusy);

  always_ff @(posedge usr_clk) begin
    if (usr_reset) begin
      state   <= ARB_IDLE;
      streak  <= '0;
      arb_err <= 1'b0;
    end else begin
      if (start) begin
        state <= rgranted ? ARB_RD : ARB_WR;
        if (!same)
          streak <= ARB_CW'(1);
        else if (!(&streak))
          streak <= streak + ARB_CW'(1);
      end
      if (bad)
        arb_err <= 1'b1;
    end
  end

  assign arb_owner = state;

endmodule

// File: tb/tb_asi_arb.sv
// tb_asi_arb: directed checks of asi_arb in three priority/limiter
// configurations sharing one clock and reset.
module tb_asi_arb;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       arv0 = 0, rb0 = 0, awv0 = 0, wb0 = 0;
  logic       rg0, wg0, err0;
  logic [1:0] own0;
  logic       arv1 = 0, rb1 = 0, awv1 = 0, wb1 = 0;
  logic       rg1, wg1, err1;
  logic [1:0] own1;
  logic       arv2 = 0, rb2 = 0, awv2 = 0, wb2 = 0;
  logic       rg2, wg2, err2;
  logic [1:0] own2;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  asi_arb #(.SLV_ARB(0), .ARB_MAXB(4)) u0 (
    .usr_clk(clk), .usr_reset(rst),
    .m_arff_rvalid(arv0), .m_rbusy(rb0),
    .m_awff_rvalid(awv0), .m_wbusy(wb0),
    .rgranted(rg0), .wgranted(wg0),
    .arb_owner(own0), .arb_err(err0)
  );

  asi_arb #(.SLV_ARB(1), .ARB_MAXB(2)) u1 (
    .usr_clk(clk), .usr_reset(rst),
    .m_arff_rvalid(arv1), .m_rbusy(rb1),
    .m_awff_rvalid(awv1), .m_wbusy(wb1),
    .rgranted(rg1), .wgranted(wg1),
    .arb_owner(own1), .arb_err(err1)
  );

  asi_arb #(.SLV_ARB(1), .ARB_MAXB(0)) u2 (
    .usr_clk(clk), .usr_reset(rst),
    .m_arff_rvalid(arv2), .m_rbusy(rb2),
    .m_awff_rvalid(awv2), .m_wbusy(wb2),
    .rgranted(rg2), .wgranted(wg2),
    .arb_owner(own2), .arb_err(err2)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  int rcnt;
  int wcnt;

  initial begin
    cyc(); cyc();
    rst = 0;
    #1;
    chk("rst_owner", own0, 2'b00);
    chk("rst_err", err0, 0);
    chk("rst_grants", {rg0, wg0}, 2'b00);

    // enter RD, then reset in the middle of the burst
    arv0 = 1; #1;
    chk("idle_rd_grant", rg0, 1);
    cyc();
    chk("own_rd", own0, 2'b01);
    arv0 = 0; rb0 = 1; #1;
    chk("hold_rd", {rg0, wg0}, 2'b10);
    rst = 1; #1;
    chk("rst_mid_grants", {rg0, wg0}, 2'b00);
    cyc();
    rst = 0; rb0 = 0; #1;
    chk("rst_mid_owner", own0, 2'b00);
    chk("rst_mid_err", err0, 0);

    // write priority, burst atomicity against held read request
    arv0 = 1; awv0 = 1; #1;
    chk("both_wr_wins", {rg0, wg0}, 2'b01);
    cyc();
    chk("own_wr", own0, 2'b10);
    awv0 = 0; wb0 = 1;
    rcnt = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (rg0 || !wg0) rcnt++;
      cyc();
    end
    chk("wr_hold_4", rcnt, 0);
    wb0 = 0; #1;
    chk("rd_after_wr", {rg0, wg0}, 2'b10);
    cyc();
    chk("own_rd2", own0, 2'b01);

    // one-cycle write valid pulse while RD owner is idle
    arv0 = 0; awv0 = 1; #1;
    chk("pulse_wr", {rg0, wg0}, 2'b01);
    cyc();
    awv0 = 0;
    chk("pulse_own", own0, 2'b10);
    chk("pulse_err", err0, 0);

    // non-owner busy raises the sticky error
    rb0 = 1; #1;
    cyc();
    rb0 = 0;
    chk("err_set", err0, 1);
    cyc(); cyc();
    chk("err_sticky", err0, 1);
    rst = 1;
    cyc();
    rst = 0; #1;
    chk("err_clear", err0, 0);

    // streak limit of 2 with read priority and single-beat bursts
    arv1 = 1; awv1 = 1; #1;
    chk("lim_d1", {rg1, wg1}, 2'b10);
    cyc();
    rb1 = 1; cyc();
    rb1 = 0; #1;
    chk("lim_d2", {rg1, wg1}, 2'b10);
    cyc();
    rb1 = 1; cyc();
    rb1 = 0; #1;
    chk("lim_d3_wr", {rg1, wg1}, 2'b01);
    cyc();
    chk("lim_own_wr", own1, 2'b10);
    wb1 = 1; cyc();
    wb1 = 0; #1;
    chk("lim_back_rd", {rg1, wg1}, 2'b10);
    cyc();
    rb1 = 1; cyc();
    rb1 = 0; #1;
    chk("lim_rd_again", {rg1, wg1}, 2'b10);
    cyc();
    rb1 = 1; cyc();
    rb1 = 0; #1;
    chk("lim_wr_again", {rg1, wg1}, 2'b01);
    cyc();
    arv1 = 0; awv1 = 0;
    chk("lim_err", err1, 0);

    // limiter disabled: read keeps the port for 100 bursts
    arv2 = 1; awv2 = 1;
    rcnt = 0; wcnt = 0;
    for (int i = 0; i < 100; i++) begin
      rb2 = 0; #1;
      if (rg2) rcnt++;
      if (wg2) wcnt++;
      cyc();
      rb2 = 1; #1;
      if (wg2) wcnt++;
      cyc();
    end
    rb2 = 0;
    chk("nolim_rd", rcnt, 100);
    chk("nolim_wr", wcnt, 0);
    chk("nolim_err", err2, 0);
    chk("nolim_own", own2, 2'b01);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
